// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - arb_state_t : lock-ownership state (ARB_IDLE, ARB_LOCK0, ARB_LOCK1)
//   - PORT0/PORT1 : port-index constants used for grant encoding
//   - addr_err()  : request address check (word alignment and range vs DEPTH)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_LOCK0 = 2'd1,
    ARB_LOCK1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // Callers zero-extend their byte address to this width so one function
  // serves any A_WIDTH up to 64 bits.
  localparam int unsigned ERR_ADDR_W = 64;

  // A request is in error when it is not word aligned or its word index falls
  // outside the memory.
  function automatic logic addr_err(input logic [ERR_ADDR_W-1:0] addr,
                                    input int unsigned          depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= ERR_ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// -----------------------------------------------------------------------------
// dmem_arb_resp
// Per-port response register. Captures the outcome of an accepted request and
// presents it as a one-cycle pulse on the following cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                request accepted on this port this cycle
//   load_rdata          read data to return (already 0 for writes/errors)
//   load_err            request was misaligned or out of range
//   resp_valid          one-cycle response pulse
//   resp_rdata          response read data, 0 when no response
//   resp_err            response error flag
// -----------------------------------------------------------------------------
module dmem_arb_resp
  import dmem_arb_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [D_WIDTH-1:0] load_rdata,
  input  logic               load_err,
  output logic               resp_valid,
  output logic [D_WIDTH-1:0] resp_rdata,
  output logic               resp_err
);

  logic               valid_q;
  logic [D_WIDTH-1:0] rdata_q;
  logic               err_q;

  // NOTE: non-blocking assignments in clocked blocks so every register samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= load;
      rdata_q <= load ? load_rdata : '0;
      err_q   <= load & load_err;
    end
  end

  // A response captured just before reset asserts must not escape while reset
  // is high, so the outputs are masked by rst as well as cleared at the edge.
  assign resp_valid = valid_q & ~rst;
  assign resp_rdata = rst ? '0 : rdata_q;
  assign resp_err   = err_q & ~rst;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the core load/store path (port 0)
// and a secondary master (port 1). One access per cycle, registered response
// one cycle after accept, error on misaligned / out-of-range addresses, and a
// lock that reserves the memory for one master across a read-modify-write.
//
// Build option: define DMEM_ARB_RR_EN for round-robin on contention in IDLE;
// otherwise port 0 has fixed priority.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pN_req_valid/ready           request handshake (N = 0, 1)
//   pN_req_we/lock/addr/wdata    request: write, keep-lock, byte addr, data
//   pN_resp_valid/rdata/err      one-cycle response pulse
//   mem_we/addr/wdata            memory write enable, word index, write data
//   mem_rdata                    combinational memory read data
//   lock_timeout                 pulse when an idle lock is forcibly released
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned D_WIDTH  = 32,
  parameter int unsigned A_WIDTH  = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_req_valid,
  output logic               p0_req_ready,
  input  logic               p0_req_we,
  input  logic               p0_req_lock,
  input  logic [A_WIDTH-1:0] p0_req_addr,
  input  logic [D_WIDTH-1:0] p0_req_wdata,
  output logic               p0_resp_valid,
  output logic [D_WIDTH-1:0] p0_resp_rdata,
  output logic               p0_resp_err,
  input  logic               p1_req_valid,
  output logic               p1_req_ready,
  input  logic               p1_req_we,
  input  logic               p1_req_lock,
  input  logic [A_WIDTH-1:0] p1_req_addr,
  input  logic [D_WIDTH-1:0] p1_req_wdata,
  output logic               p1_resp_valid,
  output logic [D_WIDTH-1:0] p1_resp_rdata,
  output logic               p1_resp_err,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               lock_timeout
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t         state_q, state_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               timeout_hit;
  logic               lock_timeout_q;

  logic               elig0, elig1;
  logic               want0, want1;
  logic               contend, contend_pick;
  logic               grant;
  logic               accept;

  logic               sel_we, sel_lock, sel_err;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;
  logic [D_WIDTH-1:0] rd_capture;

  // ---------------------------------------------------------------- grant
  assign elig0   = (state_q == ARB_IDLE) || (state_q == ARB_LOCK0);
  assign elig1   = (state_q == ARB_IDLE) || (state_q == ARB_LOCK1);
  assign want0   = p0_req_valid & elig0;
  assign want1   = p1_req_valid & elig1;
  assign contend = want0 & want1;

`ifdef DMEM_ARB_RR_EN
  // Remembers the port granted on the last contended accept; resets to port 1
  // so port 0 wins the first conflict.
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT1;
    end else if (accept && contend) begin
      last_grant_q <= grant;
    end
  end

  assign contend_pick = ~last_grant_q;
`else
  assign contend_pick = PORT0;
`endif

  assign grant  = contend ? contend_pick : (want0 ? PORT0 : PORT1);
  // Nothing is accepted while reset is high, so a write presented in a reset
  // cycle never reaches the memory.
  assign accept = (want0 | want1) & ~rst;

  assign p0_req_ready = accept & (grant == PORT0);
  assign p1_req_ready = accept & (grant == PORT1);

  // ---------------------------------------------------------- request mux
  // NOTE: every always_comb output gets a value before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sel_we    = p0_req_we;
    sel_lock  = p0_req_lock;
    sel_addr  = p0_req_addr;
    sel_wdata = p0_req_wdata;
    if (grant == PORT1) begin
      sel_we    = p1_req_we;
      sel_lock  = p1_req_lock;
      sel_addr  = p1_req_addr;
      sel_wdata = p1_req_wdata;
    end
  end

  assign sel_err = addr_err(ERR_ADDR_W'(sel_addr), DEPTH);

  // Memory side is only driven for a valid, non-error accept; otherwise held 0.
  assign mem_we    = accept & sel_we & ~sel_err;
  assign mem_addr  = (accept && !sel_err) ? (sel_addr >> 2) : '0;
  assign mem_wdata = (accept && !sel_err) ? sel_wdata : '0;

  assign rd_capture = (sel_we || sel_err) ? '0 : mem_rdata;

  // ------------------------------------------------------ lock state machine
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (accept) begin
      // While locked only the owner is eligible, so any accept here is an
      // owner request; it clears the counter even on the timeout cycle.
      if (sel_lock) begin
        state_d = (grant == PORT1) ? ARB_LOCK1 : ARB_LOCK0;
      end else begin
        state_d = ARB_IDLE;
      end
    end else if (state_q != ARB_IDLE) begin
      if (idle_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
        timeout_hit = 1'b1;
        state_d     = ARB_IDLE;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ARB_IDLE;
      idle_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      lock_timeout_q <= timeout_hit;
    end
  end

  // Pulses in the first cycle back in IDLE after a forced release.
  assign lock_timeout = lock_timeout_q & ~rst;

  // ---------------------------------------------------------- responses
  dmem_arb_resp #(.D_WIDTH(D_WIDTH)) u_resp0 (
    .clk        (clk),
    .rst        (rst),
    .load       (p0_req_ready),
    .load_rdata (rd_capture),
    .load_err   (sel_err),
    .resp_valid (p0_resp_valid),
    .resp_rdata (p0_resp_rdata),
    .resp_err   (p0_resp_err)
  );

  dmem_arb_resp #(.D_WIDTH(D_WIDTH)) u_resp1 (
    .clk        (clk),
    .rst        (rst),
    .load       (p1_req_ready),
    .load_rdata (rd_capture),
    .load_err   (sel_err),
    .resp_valid (p1_resp_valid),
    .resp_rdata (p1_resp_rdata),
    .resp_err   (p1_resp_err)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter (D_WIDTH=32, A_WIDTH=32, DEPTH=32,
// LOCK_MAX=16). A simple word memory, preloaded with 0xA0000000 + index, sits
// on the memory port. Inputs change 1 time unit after the rising edge;
// registered outputs are read there and combinational outputs 1 unit later.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_req_lock;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_resp_valid, p0_resp_err;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_lock;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_resp_valid, p1_resp_err;
  logic [31:0] p1_resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        lock_timeout;

  logic        mem_load;
  logic [31:0] mem [32];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(
    .D_WIDTH (32),
    .A_WIDTH (32),
    .DEPTH   (32),
    .LOCK_MAX(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_req_we    (p0_req_we),
    .p0_req_lock  (p0_req_lock),
    .p0_req_addr  (p0_req_addr),
    .p0_req_wdata (p0_req_wdata),
    .p0_resp_valid(p0_resp_valid),
    .p0_resp_rdata(p0_resp_rdata),
    .p0_resp_err  (p0_resp_err),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_we    (p1_req_we),
    .p1_req_lock  (p1_req_lock),
    .p1_req_addr  (p1_req_addr),
    .p1_req_wdata (p1_req_wdata),
    .p1_resp_valid(p1_resp_valid),
    .p1_resp_rdata(p1_resp_rdata),
    .p1_resp_err  (p1_resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .lock_timeout (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at the rising edge.
  assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (mem_we && mem_addr < 32) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic v, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    p0_req_valid = v;
    p0_req_we    = we;
    p0_req_lock  = lock;
    p0_req_addr  = addr;
    p0_req_wdata = wdata;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] wdata);
    p1_req_valid = v;
    p1_req_we    = we;
    p1_req_lock  = lock;
    p1_req_addr  = addr;
    p1_req_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    logic exp0;

    // ---------------- reset with both ports requesting
    rst      = 1'b1;
    mem_load = 1'b1;
    set_p0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_p1(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int r = 0; r < 2; r++) begin
      #1;
      check("rst_ready0", 32'(p0_req_ready), 32'd0);
      check("rst_ready1", 32'(p1_req_ready), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_rv0", 32'(p0_resp_valid), 32'd0);
      check("rst_rv1", 32'(p1_resp_valid), 32'd0);
      check("rst_timeout", 32'(lock_timeout), 32'd0);
      next_cycle();
      mem_load = 1'b0;
    end
    rst = 1'b0;

    // ---------------- contention: both read 0x0 for six cycles
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp0 = (i % 2 == 0);
`else
      exp0 = 1'b1;
`endif
      #1;
      check("cont_ready0", 32'(p0_req_ready), 32'(exp0));
      check("cont_ready1", 32'(p1_req_ready), 32'(!exp0));
      next_cycle();
      if (i == 5) begin
        set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      check("cont_rv0", 32'(p0_resp_valid), 32'(exp0));
      check("cont_rv1", 32'(p1_resp_valid), 32'(!exp0));
      check("cont_rdata", exp0 ? p0_resp_rdata : p1_resp_rdata, 32'hA000_0000);
    end

    // ---------------- write then back-to-back read on port 0
    set_p0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    #1;
    check("wr_ready0", 32'(p0_req_ready), 32'd1);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", mem_addr, 32'h4);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    check("wr_rv0", 32'(p0_resp_valid), 32'd1);
    check("wr_rdata0", p0_resp_rdata, 32'h0);
    check("wr_err0", 32'(p0_resp_err), 32'd0);
    set_p0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    #1;
    check("rd_ready0", 32'(p0_req_ready), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rd_rv0", 32'(p0_resp_valid), 32'd1);
    check("rd_rdata0", p0_resp_rdata, 32'hDEAD_BEEF);
    next_cycle();
    check("rd_pulse_end", 32'(p0_resp_valid), 32'd0);

    // ---------------- lock held by port 1 across read-modify-write
    set_p1(1'b1, 1'b0, 1'b1, 32'h20, 32'h0);
    #1;
    check("lk_ready1", 32'(p1_req_ready), 32'd1);
    next_cycle();
    set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_p0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("lk_rv1", 32'(p1_resp_valid), 32'd1);
    check("lk_rdata1", p1_resp_rdata, 32'hA000_0008);
    check("lk_err1", 32'(p1_resp_err), 32'd0);
    #1;
    check("lk_hold0_a", 32'(p0_req_ready), 32'd0);
    next_cycle();
    #1;
    check("lk_hold0_b", 32'(p0_req_ready), 32'd0);
    set_p1(1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFE_F00D);
    #1;
    check("lk_wr_ready1", 32'(p1_req_ready), 32'd1);
    check("lk_hold0_c", 32'(p0_req_ready), 32'd0);
    check("lk_wr_mem_we", 32'(mem_we), 32'd1);
    next_cycle();
    set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("lk_release0", 32'(p0_req_ready), 32'd1);
    next_cycle();
    set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("lk_rdata0", p0_resp_rdata, 32'hA000_0000);

    // ---------------- lock timeout after 16 idle cycles
    set_p1(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    #1;
    check("to_ready1", 32'(p1_req_ready), 32'd1);
    next_cycle();
    set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_p0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 1; k <= 18; k++) begin
      #1;
      check("to_pulse", 32'(lock_timeout), 32'(k == 17));
      if (k >= 16) check("to_ready0", 32'(p0_req_ready), 32'(k >= 17));
      next_cycle();
    end
    set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // ---------------- error requests
    set_p0(1'b1, 1'b0, 1'b0, 32'h13, 32'h0);
    #1;
    check("er_mis_ready0", 32'(p0_req_ready), 32'd1);
    check("er_mis_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    check("er_mis_rv0", 32'(p0_resp_valid), 32'd1);
    check("er_mis_err0", 32'(p0_resp_err), 32'd1);
    check("er_mis_rdata0", p0_resp_rdata, 32'h0);
    set_p0(1'b1, 1'b1, 1'b0, 32'h80, 32'h5555_5555);
    #1;
    check("er_oor_ready0", 32'(p0_req_ready), 32'd1);
    check("er_oor_mem_we", 32'(mem_we), 32'd0);
    next_cycle();
    check("er_oor_err0", 32'(p0_resp_err), 32'd1);
    check("er_oor_rdata0", p0_resp_rdata, 32'h0);
    set_p0(1'b1, 1'b0, 1'b0, 32'h7C, 32'h0);
    #1;
    check("er_top_mem_addr", mem_addr, 32'd31);
    next_cycle();
    check("er_top_err0", 32'(p0_resp_err), 32'd0);
    check("er_top_rdata0", p0_resp_rdata, 32'hA000_001F);
    set_p0(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("er_w0_err0", 32'(p0_resp_err), 32'd0);
    check("er_w0_rdata0", p0_resp_rdata, 32'hA000_0000);

    // ---------------- reset with a locked read response pending
    set_p0(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
    #1;
    check("rp_ready0", 32'(p0_req_ready), 32'd1);
    next_cycle();
    set_p0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    set_p1(1'b1, 1'b1, 1'b0, 32'h10, 32'h1234_5678);
    #1;
    check("rp_rv0_supp", 32'(p0_resp_valid), 32'd0);
    check("rp_ready1_rst", 32'(p1_req_ready), 32'd0);
    check("rp_mem_we_rst", 32'(mem_we), 32'd0);
    next_cycle();
    rst = 1'b0;
    set_p1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    check("rp_rv0_after", 32'(p0_resp_valid), 32'd0);
    #1;
    check("rp_idle_ready1", 32'(p1_req_ready), 32'd1);
    next_cycle();
    set_p1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rp_rv1", 32'(p1_resp_valid), 32'd1);
    check("rp_rdata1", p1_resp_rdata, 32'hDEAD_BEEF);
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
